imem_loader: RTL and testbench

Boot-time loader sitting upstream of the single-cycle RISC-V core and its instruction memory. Receives a framed byte stream from the host (length header, little-endian instruction words, checksum) and packs it into 32-bit words. Writes each word into instruction memory at consecutive word addresses. Holds the core in reset until a complete, checksum-valid image has been loaded.

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader_if.sv | 23 ++
 rtl/imem_loader_byte_packer.sv | 32 +++
 rtl/imem_loader.sv | 138 +++++++++++++
 tb/tb_imem_loader.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package imem_loader_pkg;

    localparam int LEN_W  = 16;
    localparam int CSUM_W = 8;

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    // States in which the loader takes bytes from the host stream.
    function automatic logic accepts_bytes(input state_t s);
        return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 8
) ();
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // Host / testbench side: drives the stream, observes the memory bus.
    modport master (
        output byte_data, byte_valid,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );

    // Loader side.
    modport slave (
        input  byte_data, byte_valid,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs four stream bytes, least significant first, into a 32-bit word.
// word_o is valid in the cycle word_done_o is high (the 4th byte is the
// live input byte, so the word can be captured without an extra cycle).
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);
    logic [23:0] data_q;
    logic [1:0]  cnt_q;

    assign word_o      = {byte_i, data_q};
    assign word_done_o = shift_i && (cnt_q == 2'd3);

    // Shift register of the first three bytes and the byte-in-word count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (clear_i) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (shift_i) begin
            data_q <= {byte_i, data_q[23:8]};
            cnt_q  <= cnt_q + 2'd1;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Receives a framed image (length, data words, checksum), writes it to
// instruction memory and releases the core once the image is verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus,
    output logic          core_rst,
    output logic          done,
    output logic          error
);
    // Largest legal word count; one bit wider so 2^LEN_W-1 compares correctly.
    localparam logic [LEN_W:0] CAPACITY = (LEN_W + 1)'(1) << ADDR_W;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    n_q, n_d;
    logic [CSUM_W-1:0]   sum_q, sum_d;
    logic [ADDR_W-1:0]   wc_q, wc_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                ready_q;

    logic                transfer;
    logic                pack_clear, pack_shift;
    logic [31:0]         pack_word;
    logic                pack_done;
    logic [LEN_W-1:0]    len_full;
    logic                last_word;

    assign transfer  = bus.byte_valid && ready_q;
    // Compare against N-1 rather than counting to N so the counter never wraps.
    assign last_word = (LEN_W'(wc_q) == (n_q - LEN_W'(1)));

    byte_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (pack_clear),
        .shift_i     (pack_shift),
        .byte_i      (bus.byte_data),
        .word_o      (pack_word),
        .word_done_o (pack_done)
    );

    // Frame sequencing, checksum accumulation and write generation.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        sum_d      = sum_q;
        wc_d       = wc_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        pack_clear = 1'b0;
        pack_shift = 1'b0;
        len_full   = {bus.byte_data, n_q[7:0]};
        case (state_q)
            S_LEN_LO: begin
                if (transfer) begin
                    n_d[7:0] = bus.byte_data;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (transfer) begin
                    n_d[LEN_W-1:8] = bus.byte_data;
                    pack_clear     = 1'b1;
                    sum_d          = '0;
                    wc_d           = '0;
                    if ({1'b0, len_full} > CAPACITY) begin
                        state_d = S_ERR;
                    end else if (len_full == '0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (transfer) begin
                    pack_shift = 1'b1;
                    sum_d      = sum_q + bus.byte_data;
                    if (pack_done) begin
                        we_d    = 1'b1;
                        addr_d  = wc_q;
                        wdata_d = pack_word;
                        if (last_word) begin
                            state_d = S_CSUM;
                        end else begin
                            wc_d = wc_q + ADDR_W'(1);
                        end
                    end
                end
            end
            S_CSUM: begin
                if (transfer) begin
                    state_d = (bus.byte_data == sum_q) ? S_DONE : S_ERR;
                end
            end
            default: ;
        endcase
    end

    // State, counters and registered outputs; ready follows the next state so
    // it is low during reset and rises on the first clock after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LEN_LO;
            n_q     <= '0;
            sum_q   <= '0;
            wc_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            sum_q   <= sum_d;
            wc_q    <= wc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= accepts_bytes(state_d);
        end
    end

    assign bus.byte_ready = ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign done           = (state_q == S_DONE);
    assign error          = (state_q == S_ERR);
    assign core_rst       = (state_q != S_DONE);
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as words are
// sent and popped when the loader pulses imem_we.
module tb_imem_loader;
    localparam int ADDR_W = 8;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic core_rst, done, error;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .core_rst (core_rst),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    wr_t         exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_writes = 0;
    logic [7:0]  tb_sum;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && bus.imem_we === 1'b1) begin
            wr_t w;
            n_writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", 64'(bus.imem_addr), 64'hFFFF_FFFF);
            end else begin
                w = exp_q.pop_front();
                check("wr_addr", 64'(bus.imem_addr), 64'(w.addr));
                check("wr_data", 64'(bus.imem_wdata), 64'(w.data));
                $display("write addr=%0d data=0x%08h", bus.imem_addr, bus.imem_wdata);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Called right after a negedge; returns on the negedge after the transfer.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit sent = 0;
        bus.byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.byte_data  = b;
        bus.byte_valid = 1'b1;
        for (int t = 0; t < 50 && !sent; t++) begin
            if (bus.byte_ready === 1'b1) begin
                @(posedge clk);
                sent = 1;
            end
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
        if (!sent) check("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_len(input logic [15:0] n, input int gap);
        send_byte(n[7:0], gap);
        send_byte(n[15:8], gap);
        tb_sum = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w, input int addr, input bit expect_write, input int maxgap);
        wr_t e;
        e.addr = ADDR_W'(addr);
        e.data = w;
        if (expect_write) exp_q.push_back(e);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = w[8*i +: 8];
            tb_sum = tb_sum + b;
            send_byte(b, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.byte_valid = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(bus.byte_ready), 64'd0);
        check("rst_we", 64'(bus.imem_we), 64'd0);
        check("rst_core_rst", 64'(core_rst), 64'd1);
        check("rst_done_error", 64'({done, error}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(bus.byte_ready), 64'd1);
    endtask

    task automatic expect_end(input string tag, input bit ok);
        check({tag, "_done"}, 64'(done), 64'(ok));
        check({tag, "_error"}, 64'(error), 64'(!ok));
        check({tag, "_core_rst"}, 64'(core_rst), 64'(!ok));
        check({tag, "_ready"}, 64'(bus.byte_ready), 64'd0);
        check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int w0;
        logic [31:0] words [256];
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;

        // Reset values while rst is held.
        @(negedge clk);
        check("init_ready", 64'(bus.byte_ready), 64'd0);
        check("init_addr", 64'(bus.imem_addr), 64'd0);
        check("init_wdata", 64'(bus.imem_wdata), 64'd0);
        check("init_we", 64'(bus.imem_we), 64'd0);
        check("init_flags", 64'({core_rst, done, error}), 64'b100);
        do_reset();

        // Two-word valid frame, data and checksum back to back.
        send_len(16'd2, 0);
        send_word(32'h0000_0513, 0, 1, 0);
        send_word(32'h0010_0093, 1, 1, 0);
        check("t1_sum_model", 64'(tb_sum), 64'hBB);
        send_byte(8'hBB, 0);
        expect_end("t1", 1'b1);
        $display("frame N=2 csum=BB done=%0b error=%0b", done, error);

        // Same frame, bad checksum.
        do_reset();
        send_len(16'd2, 1);
        send_word(32'h0000_0513, 0, 1, 1);
        send_word(32'h0010_0093, 1, 1, 1);
        send_byte(8'hBC, 0);
        expect_end("t2", 1'b0);
        $display("frame N=2 csum=BC done=%0b error=%0b", done, error);

        // Oversize length, then bytes offered while not ready are ignored.
        do_reset();
        w0 = n_writes;
        send_len(16'h0101, 0);
        check("t3_error", 64'(error), 64'd1);
        bus.byte_data  = 8'h5A;
        bus.byte_valid = 1'b1;
        repeat (4) @(negedge clk);
        bus.byte_valid = 1'b0;
        check("t3_no_write", 64'(n_writes - w0), 64'd0);
        expect_end("t3", 1'b0);
        $display("frame N=0x0101 error=%0b writes=%0d", error, n_writes - w0);

        // Empty image, good and bad checksum.
        do_reset();
        w0 = n_writes;
        send_len(16'd0, 0);
        send_byte(8'h00, 0);
        check("t4_no_write", 64'(n_writes - w0), 64'd0);
        expect_end("t4a", 1'b1);
        $display("frame N=0 csum=00 done=%0b", done);
        do_reset();
        send_len(16'd0, 0);
        send_byte(8'h01, 2);
        expect_end("t4b", 1'b0);
        $display("frame N=0 csum=01 error=%0b", error);

        // Full-capacity image with random gaps.
        do_reset();
        w0 = n_writes;
        for (int i = 0; i < 256; i++) words[i] = $urandom;
        send_len(16'd256, 2);
        for (int i = 0; i < 256; i++) send_word(words[i], i, 1, 2);
        send_byte(tb_sum, int'($urandom_range(0, 2)));
        repeat (3) @(negedge clk);
        check("t5_write_count", 64'(n_writes - w0), 64'd256);
        expect_end("t5", 1'b1);
        $display("frame N=256 done=%0b writes=%0d", done, n_writes - w0);

        // Reset mid-frame after six data bytes, then a fresh one-word frame.
        do_reset();
        send_len(16'd2, 0);
        send_word(32'h4433_2211, 0, 1, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        do_reset();
        check("t6_queue_after_rst", 64'(exp_q.size()), 64'd0);
        w0 = n_writes;
        send_len(16'd1, 0);
        send_word(32'hDEAD_BEEF, 0, 1, 1);
        send_byte(tb_sum, 0);
        check("t6_write_count", 64'(n_writes - w0), 64'd1);
        expect_end("t6", 1'b1);
        $display("frame after mid-frame rst done=%0b writes=%0d", done, n_writes - w0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
